// File: rtl/uart_buffered_if.sv
// uart_buffered_if: host-side TX/RX buffer signals and the serial pins of uart_buffered.
interface uart_buffered_if #(parameter int DATA_BITS = 8);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_strobe;
    logic                 tx_full;
    logic                 tx_busy;
    logic                 tx_pin;
    logic                 rx_pin;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_ready;
    logic                 rx_ready_clear;
    logic                 rx_overflow;
    logic                 rx_frame_error;
    logic                 rx_parity_error;
    logic                 error_clear;
    modport master (
        output tx_data, tx_strobe, rx_pin, rx_ready_clear, error_clear,
        input  tx_full, tx_busy, tx_pin, rx_data, rx_ready, rx_overflow, rx_frame_error, rx_parity_error
    );
    modport slave (
        input  tx_data, tx_strobe, rx_pin, rx_ready_clear, error_clear,
        output tx_full, tx_busy, tx_pin, rx_data, rx_ready, rx_overflow, rx_frame_error, rx_parity_error
    );
endinterface

// File: rtl/uart_buffered.sv
// uart_buffered: UART with TX/RX FIFOs, 8N1-style framing, sticky error flags.
// Define UART_PARITY_EN to add an even-parity bit in both directions.
module uart_buffered #(
    parameter int CLK_DIV   = 1250,
    parameter int DATA_BITS = 8,
    parameter int TX_DEPTH  = 16,
    parameter int RX_DEPTH  = 16
) (
    input logic            raw_clk,
    input logic            reset,
    uart_buffered_if.slave bus
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int TA = $clog2(TX_DEPTH);
    localparam int RA = $clog2(RX_DEPTH);
`ifdef UART_PARITY_EN
    localparam int SW = DATA_BITS + 1;
`else
    localparam int SW = DATA_BITS;
`endif
    localparam logic [DW-1:0] BIT_END  = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] HALF_END = DW'(CLK_DIV / 2 - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

`ifdef UART_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
`else
    localparam state_t AFTER_DATA = STOP;
`endif

    logic [DATA_BITS-1:0] tx_mem_q [TX_DEPTH];
    logic [TA:0]          tx_wp_q, tx_rp_q;
    logic                 tx_empty, tx_full, tx_push, tx_pop;
    logic [DATA_BITS-1:0] tx_head;
    logic [SW-1:0]        tx_load, tx_sh_q, tx_sh_d;
    state_t               tx_state_q, tx_state_d;
    logic [DW-1:0]        tx_div_q, tx_div_d;
    logic [2:0]           tx_bit_q, tx_bit_d;
    logic                 tx_pin_q, tx_pin_d;

    assign tx_empty = tx_wp_q == tx_rp_q;
    assign tx_full  = (tx_wp_q[TA] != tx_rp_q[TA]) && (tx_wp_q[TA-1:0] == tx_rp_q[TA-1:0]);
    assign tx_push  = bus.tx_strobe && !tx_full;
    assign tx_head  = tx_mem_q[tx_rp_q[TA-1:0]];
`ifdef UART_PARITY_EN
    assign tx_load  = {^tx_head, tx_head};
`else
    assign tx_load  = tx_head;
`endif

    always_ff @(posedge raw_clk) begin
        if (tx_push) tx_mem_q[tx_wp_q[TA-1:0]] <= bus.tx_data;
    end

    // The stop bit hands straight over to the next start bit when more words are queued.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_div_d   = tx_div_q + DW'(1);
        tx_bit_d   = tx_bit_q;
        tx_sh_d    = tx_sh_q;
        tx_pin_d   = 1'b1;
        tx_pop     = 1'b0;
        case (tx_state_q)
            IDLE: begin
                tx_div_d = '0;
                if (!tx_empty) begin
                    tx_state_d = START;
                    tx_pop     = 1'b1;
                    tx_sh_d    = tx_load;
                end
            end
            START: begin
                tx_pin_d = 1'b0;
                if (tx_div_q == BIT_END) begin
                    tx_div_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = DATA;
                end
            end
            DATA: begin
                tx_pin_d = tx_sh_q[0];
                if (tx_div_q == BIT_END) begin
                    tx_div_d   = '0;
                    tx_sh_d    = tx_sh_q >> 1;
                    tx_bit_d   = tx_bit_q + 3'd1;
                    tx_state_d = (tx_bit_q == LAST_BIT) ? AFTER_DATA : DATA;
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                tx_pin_d = tx_sh_q[0];
                if (tx_div_q == BIT_END) begin
                    tx_div_d   = '0;
                    tx_state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (tx_div_q == BIT_END) begin
                    tx_div_d   = '0;
                    tx_state_d = tx_empty ? IDLE : START;
                    tx_pop     = !tx_empty;
                    tx_sh_d    = tx_empty ? tx_sh_q : tx_load;
                end
            end
            default: tx_state_d = IDLE;
        endcase
    end

    logic [DATA_BITS-1:0] rx_mem_q [RX_DEPTH];
    logic [RA:0]          rx_wp_q, rx_rp_q;
    logic                 rx_empty, rx_full, rx_pop, rx_wr;
    logic [1:0]           rx_sync_q;
    logic                 rx_s;
    state_t               rx_state_q, rx_state_d;
    logic [DW-1:0]        rx_div_q, rx_div_d;
    logic [2:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
    logic                 rx_push, fe_set, pe_set;
    logic                 ovf_q, fe_q, pe_q;
`ifdef UART_PARITY_EN
    logic                 rx_pb_q, rx_pb_d;
`endif

    assign rx_s     = rx_sync_q[1];
    assign rx_empty = rx_wp_q == rx_rp_q;
    assign rx_full  = (rx_wp_q[RA] != rx_rp_q[RA]) && (rx_wp_q[RA-1:0] == rx_rp_q[RA-1:0]);
    assign rx_pop   = bus.rx_ready_clear && !rx_empty;
    assign rx_wr    = rx_push && (!rx_full || rx_pop);

    always_ff @(posedge raw_clk) begin
        if (rx_wr) rx_mem_q[rx_wp_q[RA-1:0]] <= rx_sh_q;
    end

    // Sampling points sit mid-bit: half a bit after the start edge, then whole bits.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_div_d   = rx_div_q + DW'(1);
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_push    = 1'b0;
        fe_set     = 1'b0;
        pe_set     = 1'b0;
`ifdef UART_PARITY_EN
        rx_pb_d    = rx_pb_q;
`endif
        case (rx_state_q)
            IDLE: begin
                rx_div_d   = '0;
                rx_state_d = rx_s ? IDLE : START;
            end
            START: begin
                if (rx_div_q == HALF_END) begin
                    rx_div_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (rx_div_q == BIT_END) begin
                    rx_div_d   = '0;
                    rx_sh_d    = {rx_s, rx_sh_q[DATA_BITS-1:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    rx_state_d = (rx_bit_q == LAST_BIT) ? AFTER_DATA : DATA;
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (rx_div_q == BIT_END) begin
                    rx_div_d   = '0;
                    rx_pb_d    = rx_s;
                    rx_state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (rx_div_q == BIT_END) begin
                    rx_div_d   = '0;
                    rx_state_d = IDLE;
                    fe_set     = !rx_s;
`ifdef UART_PARITY_EN
                    pe_set     = rx_s && ((^rx_sh_q) != rx_pb_q);
`endif
                    rx_push    = rx_s && !pe_set;
                end
            end
            default: rx_state_d = IDLE;
        endcase
    end

    always_ff @(posedge raw_clk or posedge reset) begin
        if (reset) begin
            tx_wp_q    <= '0;
            tx_rp_q    <= '0;
            tx_state_q <= IDLE;
            tx_div_q   <= '0;
            tx_bit_q   <= '0;
            tx_sh_q    <= '0;
            tx_pin_q   <= 1'b1;
            rx_wp_q    <= '0;
            rx_rp_q    <= '0;
            rx_sync_q  <= 2'b11;
            rx_state_q <= IDLE;
            rx_div_q   <= '0;
            rx_bit_q   <= '0;
            rx_sh_q    <= '0;
            ovf_q      <= 1'b0;
            fe_q       <= 1'b0;
            pe_q       <= 1'b0;
`ifdef UART_PARITY_EN
            rx_pb_q    <= 1'b0;
`endif
        end else begin
            tx_wp_q    <= tx_wp_q + (TA+1)'(tx_push);
            tx_rp_q    <= tx_rp_q + (TA+1)'(tx_pop);
            tx_state_q <= tx_state_d;
            tx_div_q   <= tx_div_d;
            tx_bit_q   <= tx_bit_d;
            tx_sh_q    <= tx_sh_d;
            tx_pin_q   <= tx_pin_d;
            rx_wp_q    <= rx_wp_q + (RA+1)'(rx_wr);
            rx_rp_q    <= rx_rp_q + (RA+1)'(rx_pop);
            rx_sync_q  <= {rx_sync_q[0], bus.rx_pin};
            rx_state_q <= rx_state_d;
            rx_div_q   <= rx_div_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            ovf_q      <= (rx_push && rx_full && !rx_pop) || (ovf_q && !bus.error_clear);
            fe_q       <= fe_set || (fe_q && !bus.error_clear);
            pe_q       <= pe_set || (pe_q && !bus.error_clear);
`ifdef UART_PARITY_EN
            rx_pb_q    <= rx_pb_d;
`endif
        end
    end

    assign bus.tx_full         = tx_full;
    assign bus.tx_busy         = !tx_empty || (tx_state_q != IDLE);
    assign bus.tx_pin          = tx_pin_q;
    assign bus.rx_data         = rx_empty ? '0 : rx_mem_q[rx_rp_q[RA-1:0]];
    assign bus.rx_ready        = !rx_empty;
    assign bus.rx_overflow     = ovf_q;
    assign bus.rx_frame_error  = fe_q;
    assign bus.rx_parity_error = pe_q;
endmodule

// File: tb/tb_uart_buffered.sv
// tb_uart_buffered: directed bench; instance a uses default parameters, instance b a fast
// divisor (16) and a 4-entry RX FIFO with its serial output looped back to its input.
module tb_uart_buffered;
    localparam int DIV_A = 1250;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_a, rst_b, lb_a, rx_drv;
    int checks = 0;
    int failures = 0;

    uart_buffered_if #(.DATA_BITS(8)) bus_a();
    uart_buffered_if #(.DATA_BITS(8)) bus_b();
    assign bus_a.rx_pin = lb_a ? bus_a.tx_pin : rx_drv;
    assign bus_b.rx_pin = bus_b.tx_pin;

    uart_buffered ua (.raw_clk(clk), .reset(rst_a), .bus(bus_a));
    uart_buffered #(.CLK_DIV(16), .RX_DEPTH(4)) ub (.raw_clk(clk), .reset(rst_b), .bus(bus_b));

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

`ifdef UART_PARITY_EN
    task automatic send_a(input logic [7:0] d, input logic stop, input int stop_len, input logic par);
`else
    task automatic send_a(input logic [7:0] d, input logic stop, input int stop_len);
`endif
        rx_drv = 1'b0;
        cyc(DIV_A);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            cyc(DIV_A);
        end
`ifdef UART_PARITY_EN
        rx_drv = par;
        cyc(DIV_A);
`endif
        rx_drv = stop;
        cyc(stop_len);
        rx_drv = 1'b1;
        cyc(DIV_A);
    endtask

    task automatic test_reset;
        rst_a = 1'b1; rst_b = 1'b1; lb_a = 1'b0; rx_drv = 1'b1;
        bus_a.tx_data = '0; bus_a.tx_strobe = 1'b0; bus_a.rx_ready_clear = 1'b0; bus_a.error_clear = 1'b0;
        bus_b.tx_data = '0; bus_b.tx_strobe = 1'b0; bus_b.rx_ready_clear = 1'b0; bus_b.error_clear = 1'b0;
        #1;
        if ({bus_a.tx_pin, bus_a.tx_busy, bus_a.tx_full, bus_a.rx_ready, bus_a.rx_overflow, bus_a.rx_frame_error, bus_a.rx_parity_error} !== 7'b1000000) begin
            failures++;
            $display("FAIL reset_a_outputs got=%b exp=1000000", {bus_a.tx_pin, bus_a.tx_busy, bus_a.tx_full, bus_a.rx_ready, bus_a.rx_overflow, bus_a.rx_frame_error, bus_a.rx_parity_error});
        end
        checks++;
        if (bus_a.rx_data !== 8'h00) begin failures++; $display("FAIL reset_a_rx_data got=%h exp=00", bus_a.rx_data); end
        checks++;
        if ({bus_b.tx_pin, bus_b.tx_busy, bus_b.tx_full, bus_b.rx_ready, bus_b.rx_overflow, bus_b.rx_frame_error, bus_b.rx_parity_error} !== 7'b1000000) begin
            failures++;
            $display("FAIL reset_b_outputs got=%b exp=1000000", {bus_b.tx_pin, bus_b.tx_busy, bus_b.tx_full, bus_b.rx_ready, bus_b.rx_overflow, bus_b.rx_frame_error, bus_b.rx_parity_error});
        end
        checks++;
        cyc(3);
        rst_a = 1'b0; rst_b = 1'b0;
        cyc(3);
        if ({bus_a.tx_pin, bus_a.tx_busy, bus_a.rx_ready} !== 3'b100) begin
            failures++;
            $display("FAIL post_reset_idle got=%b exp=100", {bus_a.tx_pin, bus_a.tx_busy, bus_a.rx_ready});
        end
        checks++;
    endtask

    task automatic test_tx_a5;
        logic [7:0] d;
        logic exp_bits [11];
        int nb;
        d = 8'hA5;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[i+1] = d[i];
`ifdef UART_PARITY_EN
        exp_bits[9] = ^d; exp_bits[10] = 1'b1; nb = 11;
`else
        exp_bits[9] = 1'b1; exp_bits[10] = 1'b1; nb = 10;
`endif
        bus_a.tx_data = d; bus_a.tx_strobe = 1'b1;
        cyc(1);
        bus_a.tx_strobe = 1'b0;
        if (bus_a.tx_pin !== 1'b1) begin failures++; $display("FAIL tx_lat_edge0 got=%b exp=1", bus_a.tx_pin); end
        checks++;
        cyc(1);
        if (bus_a.tx_pin !== 1'b1) begin failures++; $display("FAIL tx_lat_edge1 got=%b exp=1", bus_a.tx_pin); end
        checks++;
        cyc(1);
        for (int k = 0; k < nb; k++) begin
            if (bus_a.tx_pin !== exp_bits[k]) begin failures++; $display("FAIL tx_bit%0d_first got=%b exp=%b", k, bus_a.tx_pin, exp_bits[k]); end
            checks++;
            if (k == nb - 1) begin
                if (bus_a.tx_busy !== 1'b1) begin failures++; $display("FAIL tx_busy_in_stop got=%b exp=1", bus_a.tx_busy); end
                checks++;
            end
            cyc(DIV_A - 1);
            if (bus_a.tx_pin !== exp_bits[k]) begin failures++; $display("FAIL tx_bit%0d_last got=%b exp=%b", k, bus_a.tx_pin, exp_bits[k]); end
            checks++;
            if (k == nb - 1) begin
                if (bus_a.tx_busy !== 1'b0) begin failures++; $display("FAIL tx_busy_after_stop got=%b exp=0", bus_a.tx_busy); end
                checks++;
            end
            cyc(1);
        end
        if (bus_a.tx_pin !== 1'b1) begin failures++; $display("FAIL tx_idle_high got=%b exp=1", bus_a.tx_pin); end
        checks++;
    endtask

    task automatic test_glitch;
        rx_drv = 1'b0;
        cyc(300);
        rx_drv = 1'b1;
        cyc(2000);
        if ({bus_a.rx_ready, bus_a.rx_overflow, bus_a.rx_frame_error, bus_a.rx_parity_error} !== 4'b0000) begin
            failures++;
            $display("FAIL glitch_ignored got=%b exp=0000", {bus_a.rx_ready, bus_a.rx_overflow, bus_a.rx_frame_error, bus_a.rx_parity_error});
        end
        checks++;
    endtask

    task automatic test_frame_error;
`ifdef UART_PARITY_EN
        send_a(8'h3C, 1'b0, 700, 1'b0);
`else
        send_a(8'h3C, 1'b0, 700);
`endif
        if (bus_a.rx_frame_error !== 1'b1) begin failures++; $display("FAIL frame_error_set got=%b exp=1", bus_a.rx_frame_error); end
        checks++;
        if (bus_a.rx_ready !== 1'b0) begin failures++; $display("FAIL frame_error_no_push got=%b exp=0", bus_a.rx_ready); end
        checks++;
        bus_a.error_clear = 1'b1;
        cyc(1);
        bus_a.error_clear = 1'b0;
        if (bus_a.rx_frame_error !== 1'b0) begin failures++; $display("FAIL frame_error_clear got=%b exp=0", bus_a.rx_frame_error); end
        checks++;
    endtask

`ifdef UART_PARITY_EN
    task automatic test_parity;
        send_a(8'h07, 1'b1, DIV_A, 1'b1);
        if ({bus_a.rx_ready, bus_a.rx_parity_error} !== 2'b10) begin
            failures++; $display("FAIL parity_good_accept got=%b exp=10", {bus_a.rx_ready, bus_a.rx_parity_error});
        end
        checks++;
        if (bus_a.rx_data !== 8'h07) begin failures++; $display("FAIL parity_good_data got=%h exp=07", bus_a.rx_data); end
        checks++;
        bus_a.rx_ready_clear = 1'b1;
        cyc(1);
        bus_a.rx_ready_clear = 1'b0;
        send_a(8'h07, 1'b1, DIV_A, 1'b0);
        if ({bus_a.rx_ready, bus_a.rx_parity_error} !== 2'b01) begin
            failures++; $display("FAIL parity_bad_reject got=%b exp=01", {bus_a.rx_ready, bus_a.rx_parity_error});
        end
        checks++;
        bus_a.error_clear = 1'b1;
        cyc(1);
        bus_a.error_clear = 1'b0;
    endtask
`endif

    task automatic test_loopback;
        logic [7:0] words [3];
        words[0] = 8'h00; words[1] = 8'hFF; words[2] = 8'h55;
        for (int k = 0; k < 3; k++) begin
            bus_b.tx_data = words[k]; bus_b.tx_strobe = 1'b1;
            cyc(1);
        end
        bus_b.tx_strobe = 1'b0;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 2000 && bus_b.rx_ready !== 1'b1; i++) cyc(1);
            if (bus_b.rx_ready !== 1'b1) begin failures++; $display("FAIL loopback_ready%0d got=%b exp=1", k, bus_b.rx_ready); end
            checks++;
            if (bus_b.rx_data !== words[k]) begin failures++; $display("FAIL loopback_data%0d got=%h exp=%h", k, bus_b.rx_data, words[k]); end
            checks++;
            bus_b.rx_ready_clear = 1'b1;
            cyc(1);
            bus_b.rx_ready_clear = 1'b0;
        end
        if ({bus_b.rx_ready, bus_b.rx_overflow, bus_b.rx_frame_error, bus_b.rx_parity_error} !== 4'b0000) begin
            failures++;
            $display("FAIL loopback_flags got=%b exp=0000", {bus_b.rx_ready, bus_b.rx_overflow, bus_b.rx_frame_error, bus_b.rx_parity_error});
        end
        checks++;
    endtask

    task automatic test_pop_empty;
        bus_b.rx_ready_clear = 1'b1;
        cyc(1);
        bus_b.rx_ready_clear = 1'b0;
        if (bus_b.rx_ready !== 1'b0) begin failures++; $display("FAIL pop_empty_ready got=%b exp=0", bus_b.rx_ready); end
        checks++;
        bus_b.tx_data = 8'h3C; bus_b.tx_strobe = 1'b1;
        cyc(1);
        bus_b.tx_strobe = 1'b0;
        for (int i = 0; i < 2000 && bus_b.rx_ready !== 1'b1; i++) cyc(1);
        if (bus_b.rx_data !== 8'h3C) begin failures++; $display("FAIL pop_empty_next_data got=%h exp=3c", bus_b.rx_data); end
        checks++;
        bus_b.rx_ready_clear = 1'b1;
        cyc(1);
        bus_b.rx_ready_clear = 1'b0;
        if (bus_b.rx_ready !== 1'b0) begin failures++; $display("FAIL pop_empty_drained got=%b exp=0", bus_b.rx_ready); end
        checks++;
    endtask

    task automatic test_overflow;
        logic [7:0] w;
        for (int k = 0; k < 5; k++) begin
            w = 8'h11 * 8'(k + 1);
            bus_b.tx_data = w; bus_b.tx_strobe = 1'b1;
            cyc(1);
        end
        bus_b.tx_strobe = 1'b0;
        for (int i = 0; i < 4000 && bus_b.tx_busy === 1'b1; i++) cyc(1);
        cyc(40);
        if (bus_b.rx_overflow !== 1'b1) begin failures++; $display("FAIL overflow_set got=%b exp=1", bus_b.rx_overflow); end
        checks++;
        for (int k = 0; k < 4; k++) begin
            w = 8'h11 * 8'(k + 1);
            if ({bus_b.rx_ready, bus_b.rx_data} !== {1'b1, w}) begin
                failures++; $display("FAIL overflow_pop%0d got=%b/%h exp=1/%h", k, bus_b.rx_ready, bus_b.rx_data, w);
            end
            checks++;
            bus_b.rx_ready_clear = 1'b1;
            cyc(1);
            bus_b.rx_ready_clear = 1'b0;
        end
        if ({bus_b.rx_ready, bus_b.rx_overflow} !== 2'b01) begin
            failures++; $display("FAIL overflow_drained_sticky got=%b exp=01", {bus_b.rx_ready, bus_b.rx_overflow});
        end
        checks++;
        bus_b.error_clear = 1'b1;
        cyc(1);
        bus_b.error_clear = 1'b0;
        if (bus_b.rx_overflow !== 1'b0) begin failures++; $display("FAIL overflow_clear got=%b exp=0", bus_b.rx_overflow); end
        checks++;
    endtask

    task automatic test_reset_mid_frame;
        lb_a = 1'b1;
        bus_a.tx_data = 8'hA2; bus_a.tx_strobe = 1'b1;
        cyc(1);
        bus_a.tx_data = 8'h33;
        cyc(1);
        bus_a.tx_strobe = 1'b0;
        cyc(2 + 4 * DIV_A + 600 - 1);
        if (bus_a.tx_pin !== 1'b0) begin failures++; $display("FAIL rst_mid_bit3_low got=%b exp=0", bus_a.tx_pin); end
        checks++;
        rst_a = 1'b1;
        #1;
        if ({bus_a.tx_pin, bus_a.tx_busy, bus_a.tx_full, bus_a.rx_ready, bus_a.rx_overflow, bus_a.rx_frame_error, bus_a.rx_parity_error} !== 7'b1000000) begin
            failures++;
            $display("FAIL rst_mid_immediate got=%b exp=1000000", {bus_a.tx_pin, bus_a.tx_busy, bus_a.tx_full, bus_a.rx_ready, bus_a.rx_overflow, bus_a.rx_frame_error, bus_a.rx_parity_error});
        end
        checks++;
        cyc(2);
        rst_a = 1'b0;
        cyc(13000);
        if ({bus_a.tx_pin, bus_a.tx_busy, bus_a.rx_ready, bus_a.rx_frame_error} !== 4'b1000) begin
            failures++;
            $display("FAIL rst_mid_aftermath got=%b exp=1000", {bus_a.tx_pin, bus_a.tx_busy, bus_a.rx_ready, bus_a.rx_frame_error});
        end
        checks++;
        bus_a.tx_data = 8'h81; bus_a.tx_strobe = 1'b1;
        cyc(1);
        bus_a.tx_strobe = 1'b0;
        cyc(2);
        if (bus_a.tx_pin !== 1'b0) begin failures++; $display("FAIL rst_resume_start got=%b exp=0", bus_a.tx_pin); end
        checks++;
    endtask

    initial begin
        test_reset();
        test_tx_a5();
        test_glitch();
        test_frame_error();
`ifdef UART_PARITY_EN
        test_parity();
`endif
        test_loopback();
        test_pop_empty();
        test_overflow();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_buffered.md
UART_BUFFERED -- requirements
Module: uart_buffered

Interface
REQ-001 SHALL provide the following parameters:
- CLK_DIV, 1250, raw_clk cycles per bit (12 MHz / 9600); even, >= 16.
- DATA_BITS, 8, data bits per frame; legal range 5..8.
- TX_DEPTH, 16, TX FIFO entries; power of 2, >= 2.
- RX_DEPTH, 16, RX FIFO entries; power of 2, >= 2.

REQ-002 SHALL provide the following ports:
- raw_clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- tx_data  in  DATA_BITS  word to transmit.
- tx_strobe  in  1  single-cycle push of tx_data into the TX FIFO.
- tx_full  out  1  TX FIFO full.
- tx_busy  out  1  TX FIFO non-empty or frame in flight.
- tx_pin  out  1  serial output; idles high.
- rx_pin  in  1  serial input, asynchronous to raw_clk.
- rx_data  out  DATA_BITS  head of the RX FIFO; valid while rx_ready = 1.
- rx_ready  out  1  RX FIFO non-empty.
- rx_ready_clear  in  1  single-cycle pop of the RX FIFO head.
- rx_overflow  out  1  sticky: a received word was dropped because the RX FIFO was full.
- rx_frame_error  out  1  sticky: stop bit sampled low.
- rx_parity_error  out  1  sticky: parity mismatch; tied 0 when UART_PARITY_EN is undefined.
- error_clear  in  1  clears all sticky flags.

Function
REQ-003 Frame format SHALL be LSB first: 1 start bit (0), DATA_BITS data bits, optional parity bit, 1 stop bit (1); each bit lasts exactly CLK_DIV cycles.
REQ-004 tx_strobe with tx_full = 0 SHALL enqueue tx_data; with tx_full = 1 the word SHALL be dropped and FIFO contents left unchanged.
REQ-005 TX FSM states SHALL be IDLE, START, DATA, PARITY, STOP; IDLE->START when the FIFO is non-empty (head popped), DATA after CLK_DIV, PARITY (if compiled) or STOP after DATA_BITS bits, STOP->IDLE after CLK_DIV.
REQ-006 With TX idle and the FIFO empty, the start bit (tx_pin = 0) SHALL appear 2 cycles after the tx_strobe edge.
REQ-007 Queued frames SHALL go back to back: a new start bit begins the cycle after the previous stop bit ends.
REQ-008 rx_pin SHALL pass through a 2-flop synchroniser before any use.
REQ-009 RX FSM states SHALL be IDLE, START, DATA, PARITY, STOP. A synchronised 0 in IDLE enters START. At CLK_DIV/2 cycles the line is resampled: 1 returns to IDLE (glitch, no flags); 0 proceeds. Each subsequent bit is sampled at CLK_DIV-cycle intervals.
REQ-010 At the stop-bit sample the RX FSM SHALL return to IDLE immediately, so a following start bit is detected at full rate.
REQ-011 Stop bit = 0 SHALL set rx_frame_error and discard the word; stop bit = 1 SHALL push the word.
REQ-012 A push with the RX FIFO full and no pop that cycle SHALL drop the word and set rx_overflow.
REQ-013 A push and a pop in the same cycle SHALL both succeed, including when the FIFO is full; no overflow is raised.
REQ-014 rx_ready_clear while the FIFO is empty SHALL be ignored.
REQ-015 FIFO pointers SHALL be log2(DEPTH)+1 bits wide and wrap modulo 2*DEPTH; full is declared when the pointer MSBs differ and the low bits are equal.
REQ-016 Sticky flags SHALL set on their event and clear only on error_clear; if error_clear and a set event coincide, set SHALL win.

Reset
REQ-017 On reset assertion the block SHALL immediately force: tx_pin = 1; tx_busy, tx_full, rx_ready and all flags = 0; rx_data = 0; both FIFOs empty; both FSMs IDLE; divisors and bit counters 0.
REQ-018 Reset mid-frame SHALL abort the frame with no partial word pushed; operation resumes on the first edge after deassertion.

Configuration
REQ-019 Macro UART_PARITY_EN:
- Defined: an even-parity bit follows the data bits on TX; on RX it is checked, and a mismatch sets rx_parity_error and discards the word.
- Undefined: no parity bit in either direction, the PARITY states are absent, and rx_parity_error is tied 0.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- Defaults: tx_strobe with 0xA5 -> tx_pin = 0 at +2 cycles, then 1,0,1,0,0,1,0,1, then stop 1, each bit held 1250 cycles; tx_busy falls after the stop bit.
- Loopback tx_pin->rx_pin: enqueue 0x00, 0xFF, 0x55 -> rx_data pops 0x00, 0xFF, 0x55 in order; no flags set.
- RX_DEPTH = 4: send 5 frames with no pops -> rx_overflow = 1; pops return frames 1..4; error_clear clears the flag.
- Frame error: inject 0x3C with stop bit 0 -> rx_frame_error = 1 and rx_ready stays 0. Glitch: a 300-cycle low pulse -> no word pushed, no flags.
- UART_PARITY_EN defined: 0x07 sent with parity 1 -> accepted; same frame with parity 0 -> rx_parity_error = 1 and the word is discarded.
- Reset asserted during data bit 3 of a TX frame -> tx_pin = 1 immediately; FIFOs empty; no RX push.
